// File: rtl/micro_sequencer.sv
// Next-state sequencer for the microprogrammed MIPS control unit; drives the control-ROM address.
// Optional build macro MICRO_SEQ_STALL_CNT_EN adds the Wait_Cnt output (cumulative MOC-wait hold cycles).
module micro_sequencer #(
    parameter logic [6:0] FETCH_STATE = 7'd1,
    parameter int         MOC_TIMEOUT = 15,
    parameter int         TO_W        = 8
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic [2:0] NS_Mode,
    input  logic [6:0] Jump_Addr,
    input  logic       Cond_Inv,
    input  logic [6:0] State_Sel,
    input  logic       Cond,
    input  logic       MOC,
    input  logic       Stall,
    output logic [6:0] State,
    output logic       Illegal,
    output logic       Mem_Err,
`ifdef MICRO_SEQ_STALL_CNT_EN
    output logic [15:0] Wait_Cnt,
`endif
    output logic       Seq_Err
);

    typedef enum logic [2:0] {
        NS_INCR     = 3'd0,
        NS_JUMP     = 3'd1,
        NS_DISPATCH = 3'd2,
        NS_WAIT_MOC = 3'd3,
        NS_COND     = 3'd4,
        NS_FETCH    = 3'd5,
        NS_RSVD6    = 3'd6,
        NS_RSVD7    = 3'd7
    } ns_mode_e;

    localparam logic [TO_W-1:0] TO_MAX = TO_W'(MOC_TIMEOUT);

    ns_mode_e        mode;
    logic [6:0]      state_q, state_d;
    logic [TO_W-1:0] cnt_q, cnt_d;
    logic            illegal_q, illegal_d;
    logic            mem_err_q, mem_err_d;
    logic            seq_err_q, seq_err_d;
    logic            wait_hold;

    assign mode = ns_mode_e'(NS_Mode);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        illegal_d = 1'b0;
        mem_err_d = 1'b0;
        seq_err_d = 1'b0;
        wait_hold = 1'b0;
        // A stall freezes state and the timeout counter; flags drop to 0.
        if (!Stall) begin
            cnt_d = '0;
            unique case (mode)
                NS_INCR: state_d = state_q + 7'd1;
                NS_JUMP: state_d = Jump_Addr;
                NS_DISPATCH: begin
                    if (State_Sel != 7'd0) begin
                        state_d = State_Sel;
                    end else begin
                        state_d   = FETCH_STATE;
                        illegal_d = 1'b1;
                    end
                end
                NS_WAIT_MOC: begin
                    if (MOC) begin
                        state_d = state_q + 7'd1;
                    end else if (cnt_q != TO_MAX) begin
                        cnt_d     = cnt_q + 1'b1;
                        wait_hold = 1'b1;
                    end else begin
                        state_d   = FETCH_STATE;
                        mem_err_d = 1'b1;
                    end
                end
                NS_COND:  state_d = (Cond ^ Cond_Inv) ? Jump_Addr : state_q + 7'd1;
                NS_FETCH: state_d = FETCH_STATE;
                default: begin
                    state_d   = FETCH_STATE;
                    seq_err_d = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q   <= 7'd0;
            cnt_q     <= '0;
            illegal_q <= 1'b0;
            mem_err_q <= 1'b0;
            seq_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            illegal_q <= illegal_d;
            mem_err_q <= mem_err_d;
            seq_err_q <= seq_err_d;
        end
    end

    assign State   = state_q;
    assign Illegal = illegal_q;
    assign Mem_Err = mem_err_q;
    assign Seq_Err = seq_err_q;

`ifdef MICRO_SEQ_STALL_CNT_EN
    logic [15:0] wcnt_q, wcnt_d;

    // Saturating total of hold cycles; the abort cycle itself is not a hold.
    always_comb begin
        wcnt_d = wcnt_q;
        if (wait_hold && wcnt_q != 16'hFFFF) begin
            wcnt_d = wcnt_q + 16'd1;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            wcnt_q <= 16'd0;
        end else begin
            wcnt_q <= wcnt_d;
        end
    end

    assign Wait_Cnt = wcnt_q;
`endif

endmodule

// File: tb/tb_micro_sequencer.sv
// Scoreboard bench for micro_sequencer: each step pushes its expected State/flags,
// and the registered result is popped and compared one clock later.
module tb_micro_sequencer;

    logic       Clk;
    logic       Reset_n;
    logic [2:0] NS_Mode;
    logic [6:0] Jump_Addr;
    logic       Cond_Inv;
    logic [6:0] State_Sel;
    logic       Cond;
    logic       MOC;
    logic       Stall;
    logic [6:0] State;
    logic       Illegal;
    logic       Mem_Err;
    logic       Seq_Err;
`ifdef MICRO_SEQ_STALL_CNT_EN
    logic [15:0] Wait_Cnt;
`endif

    typedef struct packed {
        logic [6:0] st;
        logic       ill;
        logic       me;
        logic       se;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    exp_t got;
    int   n_cmp = 0;
    int   n_err = 0;

    micro_sequencer #(
        .FETCH_STATE(7'd1),
        .MOC_TIMEOUT(15),
        .TO_W(8)
    ) dut (
        .Clk(Clk),
        .Reset_n(Reset_n),
        .NS_Mode(NS_Mode),
        .Jump_Addr(Jump_Addr),
        .Cond_Inv(Cond_Inv),
        .State_Sel(State_Sel),
        .Cond(Cond),
        .MOC(MOC),
        .Stall(Stall),
        .State(State),
        .Illegal(Illegal),
        .Mem_Err(Mem_Err),
`ifdef MICRO_SEQ_STALL_CNT_EN
        .Wait_Cnt(Wait_Cnt),
`endif
        .Seq_Err(Seq_Err)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic drive(input logic [2:0] m, input logic [6:0] ja, input logic ci,
                         input logic [6:0] ss, input logic c, input logic moc, input logic stl);
        NS_Mode = m; Jump_Addr = ja; Cond_Inv = ci; State_Sel = ss;
        Cond = c; MOC = moc; Stall = stl;
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset();
        drive(3'd5, 7'd0, 1'b0, 7'd0, 1'b0, 1'b0, 1'b0);
        Reset_n = 1'b0;
        tick();
        sb.push_back('{7'd0, 1'b0, 1'b0, 1'b0});
        e = sb.pop_front(); got = {State, Illegal, Mem_Err, Seq_Err}; n_cmp++;
        if (got !== e) begin
            n_err++;
            $display("FAIL reset_hold got=%h exp=%h", got, e);
        end
        Reset_n = 1'b1;
        drive(3'd1, 7'd40, 1'b0, 7'd0, 1'b0, 1'b0, 1'b0);
        tick();
        sb.push_back('{7'd40, 1'b0, 1'b0, 1'b0});
        e = sb.pop_front(); got = {State, Illegal, Mem_Err, Seq_Err}; n_cmp++;
        if (got !== e) begin
            n_err++;
            $display("FAIL reset_jump40 got=%h exp=%h", got, e);
        end
        // Mid-cycle assertion must clear State without a clock edge.
        drive(3'd7, 7'd0, 1'b0, 7'd0, 1'b0, 1'b0, 1'b0);
        #2;
        Reset_n = 1'b0;
        #1;
        sb.push_back('{7'd0, 1'b0, 1'b0, 1'b0});
        e = sb.pop_front(); got = {State, Illegal, Mem_Err, Seq_Err}; n_cmp++;
        if (got !== e) begin
            n_err++;
            $display("FAIL reset_async got=%h exp=%h", got, e);
        end
        tick();
        Reset_n = 1'b1;
    endtask

    // Shared stepping for the table-driven tasks: push expectation, clock, pop.
    task automatic step(input logic [2:0] m, input logic [6:0] ja, input logic ci,
                        input logic [6:0] ss, input logic c, input logic moc, input logic stl,
                        input exp_t x);
        drive(m, ja, ci, ss, c, moc, stl);
        sb.push_back(x);
        tick();
    endtask

    task automatic test_dispatch();
        step(3'd1, 7'd4, 0, 7'd0, 0, 0, 0, '{7'd4, 1'b0, 1'b0, 1'b0});
        step(3'd2, 7'd0, 0, 7'd18, 0, 0, 0, '{7'd18, 1'b0, 1'b0, 1'b0});
        step(3'd1, 7'd4, 0, 7'd0, 0, 0, 0, '{7'd4, 1'b0, 1'b0, 1'b0});
        step(3'd2, 7'd0, 0, 7'd0, 0, 0, 0, '{7'd1, 1'b1, 1'b0, 1'b0});
        step(3'd0, 7'd0, 0, 7'd0, 0, 0, 0, '{7'd2, 1'b0, 1'b0, 1'b0});
        step(3'd1, 7'd9, 0, 7'd0, 0, 0, 0, '{7'd9, 1'b0, 1'b0, 1'b0});
        step(3'd2, 7'd0, 0, 7'd9, 0, 0, 0, '{7'd9, 1'b0, 1'b0, 1'b0});
        while (sb.size() != 0) begin end
    endtask

    task automatic run_table(input string name, input int n,
                             input logic [2:0] m[], input logic [6:0] ja[], input logic ci[],
                             input logic [6:0] ss[], input logic c[], input logic moc[],
                             input logic stl[], input exp_t x[]);
        for (int i = 0; i < n; i++) begin
            drive(m[i], ja[i], ci[i], ss[i], c[i], moc[i], stl[i]);
            sb.push_back(x[i]);
            tick();
            e = sb.pop_front(); got = {State, Illegal, Mem_Err, Seq_Err}; n_cmp++;
            if (got !== e) begin
                n_err++;
                $display("FAIL %s[%0d] got st=%0d ill=%b me=%b se=%b exp st=%0d ill=%b me=%b se=%b",
                         name, i, got.st, got.ill, got.me, got.se, e.st, e.ill, e.me, e.se);
            end
        end
    endtask

    // Dynamic stimulus table filled by the scenario tasks below.
    logic [2:0] t_m[];
    logic [6:0] t_ja[];
    logic       t_ci[];
    logic [6:0] t_ss[];
    logic       t_c[];
    logic       t_moc[];
    logic       t_stl[];
    exp_t       t_x[];
    int         t_n;

    task automatic tbl_clear();
        t_n = 0;
        t_m = new[64]; t_ja = new[64]; t_ci = new[64]; t_ss = new[64];
        t_c = new[64]; t_moc = new[64]; t_stl = new[64]; t_x = new[64];
    endtask

    task automatic tbl_add(input logic [2:0] m, input logic [6:0] ja, input logic ci,
                           input logic [6:0] ss, input logic c, input logic moc, input logic stl,
                           input logic [6:0] xs, input logic xi, input logic xm, input logic xe);
        t_m[t_n] = m; t_ja[t_n] = ja; t_ci[t_n] = ci; t_ss[t_n] = ss;
        t_c[t_n] = c; t_moc[t_n] = moc; t_stl[t_n] = stl;
        t_x[t_n] = '{xs, xi, xm, xe};
        t_n++;
    endtask

    task automatic test_dispatch_tbl();
        tbl_clear();
        tbl_add(3'd1, 7'd4, 0, 7'd0, 0, 0, 0, 7'd4, 0, 0, 0);
        tbl_add(3'd2, 7'd0, 0, 7'd18, 0, 0, 0, 7'd18, 0, 0, 0);
        tbl_add(3'd1, 7'd4, 0, 7'd0, 0, 0, 0, 7'd4, 0, 0, 0);
        tbl_add(3'd2, 7'd0, 0, 7'd0, 0, 0, 0, 7'd1, 1, 0, 0);
        tbl_add(3'd0, 7'd0, 0, 7'd0, 0, 0, 0, 7'd2, 0, 0, 0);
        tbl_add(3'd1, 7'd9, 0, 7'd0, 0, 0, 0, 7'd9, 0, 0, 0);
        tbl_add(3'd2, 7'd0, 0, 7'd9, 0, 0, 0, 7'd9, 0, 0, 0);
        run_table("dispatch", t_n, t_m, t_ja, t_ci, t_ss, t_c, t_moc, t_stl, t_x);
    endtask

    task automatic test_cond();
        tbl_clear();
        tbl_add(3'd1, 7'd11, 0, 7'd0, 0, 0, 0, 7'd11, 0, 0, 0);
        tbl_add(3'd4, 7'd50, 0, 7'd0, 1, 0, 0, 7'd50, 0, 0, 0);
        tbl_add(3'd1, 7'd11, 0, 7'd0, 0, 0, 0, 7'd11, 0, 0, 0);
        tbl_add(3'd4, 7'd50, 1, 7'd0, 1, 0, 0, 7'd12, 0, 0, 0);
        tbl_add(3'd4, 7'd50, 0, 7'd0, 0, 0, 0, 7'd13, 0, 0, 0);
        tbl_add(3'd4, 7'd99, 1, 7'd0, 0, 0, 0, 7'd99, 0, 0, 0);
        run_table("cond", t_n, t_m, t_ja, t_ci, t_ss, t_c, t_moc, t_stl, t_x);
    endtask

    task automatic test_timeout();
        tbl_clear();
        tbl_add(3'd1, 7'd13, 0, 7'd0, 0, 0, 0, 7'd13, 0, 0, 0);
        for (int i = 1; i <= 20; i++) begin
            if (i <= 15)      tbl_add(3'd3, 7'd0, 0, 7'd0, 0, 0, 0, 7'd13, 0, 0, 0);
            else if (i == 16) tbl_add(3'd3, 7'd0, 0, 7'd0, 0, 0, 0, 7'd1, 0, 1, 0);
            else              tbl_add(3'd3, 7'd0, 0, 7'd0, 0, 0, 0, 7'd1, 0, 0, 0);
        end
        run_table("timeout", t_n, t_m, t_ja, t_ci, t_ss, t_c, t_moc, t_stl, t_x);
        tbl_clear();
        tbl_add(3'd1, 7'd13, 0, 7'd0, 0, 0, 0, 7'd13, 0, 0, 0);
        for (int i = 1; i <= 15; i++) tbl_add(3'd3, 7'd0, 0, 7'd0, 0, 0, 0, 7'd13, 0, 0, 0);
        tbl_add(3'd3, 7'd0, 0, 7'd0, 0, 1, 0, 7'd14, 0, 0, 0);
        run_table("moc_on_timeout", t_n, t_m, t_ja, t_ci, t_ss, t_c, t_moc, t_stl, t_x);
    endtask

    task automatic test_stall();
        tbl_clear();
        tbl_add(3'd1, 7'd13, 0, 7'd0, 0, 0, 0, 7'd13, 0, 0, 0);
        for (int i = 0; i < 7; i++) tbl_add(3'd3, 7'd0, 0, 7'd0, 0, 0, 0, 7'd13, 0, 0, 0);
        for (int i = 0; i < 5; i++) tbl_add(3'd7, 7'd77, 0, 7'd0, 1, 1, 1, 7'd13, 0, 0, 0);
        for (int i = 0; i < 8; i++) tbl_add(3'd3, 7'd0, 0, 7'd0, 0, 0, 0, 7'd13, 0, 0, 0);
        tbl_add(3'd3, 7'd0, 0, 7'd0, 0, 0, 0, 7'd1, 0, 1, 0);
        run_table("stall_wait", t_n, t_m, t_ja, t_ci, t_ss, t_c, t_moc, t_stl, t_x);
    endtask

    task automatic test_wrap_reserved();
        tbl_clear();
        tbl_add(3'd1, 7'd127, 0, 7'd0, 0, 0, 0, 7'd127, 0, 0, 0);
        tbl_add(3'd0, 7'd0, 0, 7'd0, 0, 0, 0, 7'd0, 0, 0, 0);
        tbl_add(3'd0, 7'd0, 0, 7'd0, 0, 0, 0, 7'd1, 0, 0, 0);
        tbl_add(3'd1, 7'd20, 0, 7'd0, 0, 0, 0, 7'd20, 0, 0, 0);
        tbl_add(3'd7, 7'd0, 0, 7'd0, 0, 0, 0, 7'd1, 0, 0, 1);
        tbl_add(3'd6, 7'd0, 0, 7'd0, 0, 0, 1, 7'd1, 0, 0, 0);
        tbl_add(3'd1, 7'd30, 0, 7'd0, 0, 0, 0, 7'd30, 0, 0, 0);
        tbl_add(3'd6, 7'd0, 0, 7'd0, 0, 0, 0, 7'd1, 0, 0, 1);
        tbl_add(3'd1, 7'd9, 0, 7'd0, 0, 0, 0, 7'd9, 0, 0, 0);
        tbl_add(3'd5, 7'd0, 0, 7'd0, 0, 0, 0, 7'd1, 0, 0, 0);
        run_table("wrap_reserved", t_n, t_m, t_ja, t_ci, t_ss, t_c, t_moc, t_stl, t_x);
    endtask

    task automatic test_back_to_back();
        tbl_clear();
        tbl_add(3'd2, 7'd0, 0, 7'd0, 0, 0, 0, 7'd1, 1, 0, 0);
        tbl_add(3'd2, 7'd0, 0, 7'd0, 0, 0, 0, 7'd1, 1, 0, 0);
        tbl_add(3'd7, 7'd0, 0, 7'd0, 0, 0, 0, 7'd1, 0, 0, 1);
        tbl_add(3'd2, 7'd0, 0, 7'd55, 0, 0, 0, 7'd55, 0, 0, 0);
        tbl_add(3'd3, 7'd0, 0, 7'd0, 0, 1, 0, 7'd56, 0, 0, 0);
        run_table("back_to_back", t_n, t_m, t_ja, t_ci, t_ss, t_c, t_moc, t_stl, t_x);
    endtask

`ifdef MICRO_SEQ_STALL_CNT_EN
    task automatic test_wait_cnt();
        Reset_n = 1'b0;
        tick();
        Reset_n = 1'b1;
        tbl_clear();
        tbl_add(3'd1, 7'd13, 0, 7'd0, 0, 0, 0, 7'd13, 0, 0, 0);
        for (int i = 0; i < 3; i++) tbl_add(3'd3, 7'd0, 0, 7'd0, 0, 0, 0, 7'd13, 0, 0, 0);
        tbl_add(3'd3, 7'd0, 0, 7'd0, 0, 1, 0, 7'd14, 0, 0, 0);
        tbl_add(3'd1, 7'd13, 0, 7'd0, 0, 0, 0, 7'd13, 0, 0, 0);
        for (int i = 0; i < 4; i++) tbl_add(3'd3, 7'd0, 0, 7'd0, 0, 0, 0, 7'd13, 0, 0, 0);
        tbl_add(3'd3, 7'd0, 0, 7'd0, 0, 0, 1, 7'd13, 0, 0, 0);
        tbl_add(3'd3, 7'd0, 0, 7'd0, 0, 1, 0, 7'd14, 0, 0, 0);
        run_table("wait_cnt_seq", t_n, t_m, t_ja, t_ci, t_ss, t_c, t_moc, t_stl, t_x);
        n_cmp++;
        if (Wait_Cnt !== 16'd7) begin
            n_err++;
            $display("FAIL wait_cnt got=%0d exp=7", Wait_Cnt);
        end
    endtask
`endif

    initial begin
        drive(3'd5, 7'd0, 1'b0, 7'd0, 1'b0, 1'b0, 1'b0);
        Reset_n = 1'b0;
        #12;
        test_reset();
        test_dispatch_tbl();
        test_cond();
        test_timeout();
        test_stall();
        test_wrap_reserved();
        test_back_to_back();
`ifdef MICRO_SEQ_STALL_CNT_EN
        test_wait_cnt();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/micro_sequencer.md
Name: micro_sequencer

Overview:
- Next-state sequencer for the microprogrammed MIPS control unit.
- Holds the current control state. Each cycle it selects the next state from these sources:
  - the microinstruction's next-state mode,
  - the instruction encoder's dispatch target (State_Sel),
  - the ALU condition flag,
  - the memory-operation-complete handshake.
- Drives the control-ROM address.
- Aborts hung memory waits with a timeout.
- Flags undecodable instructions.

Parameters:
- FETCH_STATE, 7'd1, state entered on fetch, illegal-instruction recovery and memory timeout.
- MOC_TIMEOUT, 15, maximum consecutive MOC-low wait cycles tolerated before abort (1..255).
- TO_W, 8, width of the timeout counter; must hold MOC_TIMEOUT.

Ports:
- Clk  in  1  system clock, rising edge.
- Reset_n  in  1  asynchronous active-low reset.
- NS_Mode  in  3  next-state mode field from the current microinstruction.
- Jump_Addr  in  7  jump/branch target field from the microinstruction.
- Cond_Inv  in  1  invert condition for COND mode.
- State_Sel  in  7  dispatch target from the instruction encoder; 0 = undecoded.
- Cond  in  1  ALU condition flag.
- MOC  in  1  memory operation complete.
- Stall  in  1  freeze the sequencer (debug/hazard hold).
- State  out  7  current control state / ROM address.
- Illegal  out  1  one-cycle pulse on dispatch of an undecoded instruction.
- Mem_Err  out  1  one-cycle pulse on memory-wait timeout.
- Seq_Err  out  1  one-cycle pulse on a reserved NS_Mode.

Behaviour:
- **Reset:** Clk single clock; reset is asynchronous and active-low (Reset_n).
  - While Reset_n=0: State=7'd0, Illegal=Mem_Err=Seq_Err=0, timeout counter=0.
  - The first rising edge after release evaluates state 0's microinstruction normally.
  - Reset asserted mid-wait or mid-dispatch aborts immediately; no partial update.
- **Registered outputs:** all outputs are registered. Illegal/Mem_Err/Seq_Err assert in the same cycle State takes the corresponding recovery value. Otherwise they are 0.
- **Stall=1:** highest priority after reset. State, timeout counter and error flags hold; error flags are forced to 0 during the stall cycle. Inputs are ignored.
- **Next state when Stall=0, by NS_Mode:**
  - 3'd0 INCR: State+1, 7-bit wrap (127 -> 0).
  - 3'd1 JUMP: Jump_Addr.
  - 3'd2 DISPATCH: State_Sel if nonzero. Else FETCH_STATE with Illegal=1.
  - 3'd3 WAIT_MOC: see the WAIT_MOC rules below.
  - 3'd4 COND: Jump_Addr if (Cond ^ Cond_Inv)=1, else State+1.
  - 3'd5 FETCH: FETCH_STATE.
  - 3'd6, 3'd7 reserved: FETCH_STATE with Seq_Err=1.
- **WAIT_MOC:**
  - MOC=1: State+1, counter cleared.
  - MOC=0 and counter<MOC_TIMEOUT: State holds, counter+1.
  - MOC=0 and counter==MOC_TIMEOUT: State=FETCH_STATE, Mem_Err=1, counter cleared.
  - Net effect: MOC_TIMEOUT low-MOC cycles are tolerated; the abort happens on cycle MOC_TIMEOUT+1.
- **Counter:** cleared on any non-stalled cycle whose mode is not WAIT_MOC.
- **MOC timing:** MOC arriving exactly on the timeout cycle wins; it is a normal completion with no Mem_Err.
- **Other rules:**
  - The jump target in JUMP/COND is taken verbatim with no range check.
  - Dispatch of a self-loop target is legal.

Optional Feature:
- Macro MICRO_SEQ_STALL_CNT_EN.
- When defined:
  - Adds output Wait_Cnt[15:0]: the total cycles spent holding in WAIT_MOC with MOC=0 since reset.
  - Saturates at 16'hFFFF.
  - Does not increment during Stall.
  - Reset value 0.
  - Not cleared by timeout.
- When undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- **Reset:** Reset_n low mid-run with State=7'd40 -> State=0 immediately, without waiting for Clk; all flags 0.
- **Dispatch:** State=4, NS_Mode=2, State_Sel=7'd18 -> next State=18, Illegal=0. Repeat with State_Sel=0 -> State=1, Illegal=1 for exactly one cycle.
- **COND:** State=11, NS_Mode=4, Jump_Addr=7'd50, Cond=1, Cond_Inv=0 -> State=50. With Cond_Inv=1 -> State=12.
- **Timeout:**
  - NS_Mode=3 at State=13, MOC low for 20 cycles, MOC_TIMEOUT=15 -> State holds 13 for 15 cycles, then State=1 with Mem_Err pulse.
  - Repeat with MOC=1 on the 16th cycle -> State=14, no Mem_Err.
- **Stall, wrap, reserved:**
  - Stall=1 for 5 cycles during a WAIT_MOC hold -> counter frozen; timeout occurs 5 cycles later than unstalled.
  - INCR at State=127 -> State=0.
  - NS_Mode=7 -> State=1, Seq_Err pulse.
- **Stall-count feature (with MICRO_SEQ_STALL_CNT_EN):** two waits of 3 and 4 low-MOC cycles -> Wait_Cnt=7.
